// File: rtl/ads_pkg.sv
// Shared definitions for the ADC sample path: decimator FSM states and the
// default sample/block-size parameters used by the ADC controller as well.
package ads_pkg;

  localparam int ADS_DATA_WIDTH = 24;
  localparam int ADS_MAX_LOG2_N = 8;

  typedef enum logic [1:0] {
    ADS_IDLE  = 2'd0,
    ADS_ACCUM = 2'd1,
    ADS_EMIT  = 2'd2
  } ads_state_t;

  function automatic logic [3:0] ads_clamp_log2(input logic [3:0] v,
                                                input int unsigned max_log2);
    if (32'(v) > max_log2) return 4'(max_log2);
    return v;
  endfunction

endpackage

// File: rtl/ads_sample_decimator_if.sv
// Sample-in / result-out bus of the decimator.
interface ads_sample_decimator_if #(
  parameter int DATA_WIDTH = ads_pkg::ADS_DATA_WIDTH
) ();

  // in_valid is a one-cycle strobe with no back-pressure: the sample is taken
  // on every rising edge where it is high. Results follow valid/ready: a
  // transfer happens on each edge with out_valid && out_ready, and out_* stay
  // stable while out_valid is high and out_ready is low.
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] out_min;
  logic [DATA_WIDTH-1:0] out_max;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_min, out_max
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_min, out_max
  );

endinterface

// File: rtl/ads_minmax_track.sv
// Signed running minimum/maximum of the samples in the current block.
module ads_minmax_track import ads_pkg::*; #(
  parameter int DATA_WIDTH = ADS_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load,
  input  logic                         update,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0] min_val,
  output logic signed [DATA_WIDTH-1:0] max_val
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_val <= '0;
      max_val <= '0;
    end else if (load) begin
      min_val <= sample;
      max_val <= sample;
    end else if (update) begin
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end

endmodule

// File: rtl/ads_sample_decimator.sv
// Block-average decimator: sums 2^log2_n ADC samples, emits floor(mean) plus
// the block min/max, with a sticky overrun flag when a result is dropped.
module ads_sample_decimator import ads_pkg::*; #(
  parameter int DATA_WIDTH = ADS_DATA_WIDTH,
  parameter int MAX_LOG2_N = ADS_MAX_LOG2_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            log2_n,
  input  logic                  clear_overrun,
  output logic                  overrun,
  output logic                  busy,
  output ads_state_t            state_dbg,
  ads_sample_decimator_if.slave bus
);

  localparam int AW = DATA_WIDTH + MAX_LOG2_N;
  localparam int CW = MAX_LOG2_N + 1;

  ads_state_t                   state;
  logic [CW-1:0]                count;
  logic [CW-1:0]                cnt_next;
  logic signed [AW-1:0]         acc;
  logic signed [AW-1:0]         acc_next;
  logic signed [AW-1:0]         sample_ext;
  logic [3:0]                   blk_log2;
  logic [3:0]                   log2_clamped;
  logic [3:0]                   log2_used;
  logic                         accept;
  logic                         first;
  logic                         block_full;
  logic                         result_done;
  logic                         result_load;
  logic                         result_drop;
  logic                         pop;
  logic                         out_valid_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic [DATA_WIDTH-1:0]        out_min_q;
  logic [DATA_WIDTH-1:0]        out_max_q;
  logic signed [DATA_WIDTH-1:0] min_q;
  logic signed [DATA_WIDTH-1:0] max_q;

  // A sample arriving during EMIT opens the next block, so it counts as first.
  assign accept       = enable && bus.in_valid && (state == ADS_ACCUM || state == ADS_EMIT);
  assign first        = (state == ADS_EMIT) || (count == '0);
  assign log2_clamped = ads_clamp_log2(log2_n, MAX_LOG2_N);
  assign log2_used    = first ? log2_clamped : blk_log2;
  assign sample_ext   = {{MAX_LOG2_N{bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
  assign acc_next     = first ? sample_ext : acc + sample_ext;
  assign cnt_next     = first ? CW'(1) : count + 1'b1;
  assign block_full   = (cnt_next == (CW'(1) << log2_used));

  assign pop          = out_valid_q && bus.out_ready;
  assign result_done  = enable && (state == ADS_EMIT);
  assign result_load  = result_done && (!out_valid_q || pop);
  assign result_drop  = result_done && out_valid_q && !bus.out_ready;

  ads_minmax_track #(.DATA_WIDTH(DATA_WIDTH)) u_minmax (
    .clk     (clk),
    .rst     (rst),
    .clear   (!enable),
    .load    (accept && first),
    .update  (accept && !first),
    .sample  (bus.in_data),
    .min_val (min_q),
    .max_val (max_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ADS_IDLE;
      count       <= '0;
      acc         <= '0;
      blk_log2    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (result_drop)        overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;

      // The result register is independent of enable so a pending result survives.
      if (result_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= DATA_WIDTH'(acc >>> blk_log2);
        out_min_q   <= min_q;
        out_max_q   <= max_q;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end

      if (!enable) begin
        state <= ADS_IDLE;
        count <= '0;
        acc   <= '0;
      end else begin
        case (state)
          ADS_IDLE: state <= ADS_ACCUM;
          ADS_ACCUM, ADS_EMIT: begin
            if (accept) begin
              acc   <= acc_next;
              count <= cnt_next;
              if (first) blk_log2 <= log2_clamped;
              state <= block_full ? ADS_EMIT : ADS_ACCUM;
            end else begin
              if (state == ADS_EMIT) count <= '0;
              state <= ADS_ACCUM;
            end
          end
          default: state <= ADS_IDLE;
        endcase
      end
    end
  end

  assign busy          = (state != ADS_IDLE);
  assign state_dbg     = state;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_max   = out_max_q;

endmodule

// File: tb/tb_ads_sample_decimator.sv
// Scoreboard bench for ads_sample_decimator: a reference block-average model
// queues expected results, a negedge monitor pops them on each handshake.
module tb_ads_sample_decimator;
  import ads_pkg::*;

  localparam int DW = 24;
  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] log2_n;
  logic       clear_overrun;
  logic       overrun;
  logic       busy;
  ads_state_t state_dbg;

  ads_sample_decimator_if #(.DATA_WIDTH(DW)) bus ();

  ads_sample_decimator #(.DATA_WIDTH(DW), .MAX_LOG2_N(ML)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .log2_n        (log2_n),
    .clear_overrun (clear_overrun),
    .overrun       (overrun),
    .busy          (busy),
    .state_dbg     (state_dbg),
    .bus           (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3*DW-1:0] exp_q[$];

  // reference model state for the block in progress
  longint m_sum, m_min, m_max;
  int     m_cnt = 0;
  int     m_l   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d results still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%h min=%h max=%h, expected no result",
                 bus.out_data, bus.out_min, bus.out_max);
      end else begin
        logic [3*DW-1:0] e;
        e = exp_q.pop_front();
        if ({bus.out_data, bus.out_min, bus.out_max} !== e) begin
          errors++;
          $display("FAIL result: got data=%h min=%h max=%h, expected data=%h min=%h max=%h",
                   bus.out_data, bus.out_min, bus.out_max,
                   e[3*DW-1:2*DW], e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks: all called at posedge+1
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_clear();
    m_cnt = 0;
  endtask

  task automatic send(input logic signed [DW-1:0] x);
    longint mean;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    if (m_cnt == 0) begin
      m_l   = (log2_n > ML) ? ML : int'(log2_n);
      m_sum = x;
      m_min = x;
      m_max = x;
    end else begin
      m_sum += x;
      if (x < m_min) m_min = x;
      if (x > m_max) m_max = x;
    end
    m_cnt++;
    if (m_cnt == (1 << m_l)) begin
      mean = m_sum >>> m_l;
      exp_q.push_back({DW'(mean), DW'(m_min), DW'(m_max)});
      m_cnt = 0;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; log2_n = 4'd0; clear_overrun = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    idle(3);
    checks += 7;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    if (bus.out_min !== '0) begin errors++; $display("FAIL reset_out_min: got %h expected 0", bus.out_min); end
    if (bus.out_max !== '0) begin errors++; $display("FAIL reset_out_max: got %h expected 0", bus.out_max); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (state_dbg !== ADS_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ADS_IDLE); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_block();
    bus.out_ready = 1'b1;
    log2_n = 4'd2;
    enable = 1'b1;
    idle(1);
    send(24'sd50);
    send(24'sd60);
    model_clear();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    idle(1);
    repeat (4) send(24'sd3);
    wait_drain("mid_reset");
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b0;
    log2_n = 4'd2;
    send(24'sd4); send(24'sd8); send(24'sd12); send(24'sd16);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_on_time: out_valid got %b expected 1", bus.out_valid); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain("basic");
  endtask

  task automatic test_floor();
    log2_n = 4'd1;
    send(-24'sd3);
    send(-24'sd4);
    wait_drain("floor");
  endtask

  task automatic test_wide();
    log2_n = 4'd8;
    repeat (256) send(24'sh7FFFFF);
    log2_n = 4'd12;
    repeat (256) send(24'sh800000);
    wait_drain("wide");
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    log2_n = 4'd0;
    send(24'sd5);
    idle(3);
    send(24'sd6);
    void'(exp_q.pop_back());
    idle(3);
    checks += 2;
    if (bus.out_data !== 24'd5) begin errors++; $display("FAIL overrun_keep_old: got %0d expected 5", bus.out_data); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    clear_overrun = 1'b1;
    idle(1);
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    send(24'sd7);
    void'(exp_q.pop_back());
    clear_overrun = 1'b1;
    idle(1);
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b expected 1", overrun); end
    clear_overrun = 1'b1;
    idle(1);
    clear_overrun = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("overrun");
  endtask

  task automatic test_enable_drop();
    bus.out_ready = 1'b0;
    log2_n = 4'd0;
    send(24'sd9);
    idle(2);
    log2_n = 4'd2;
    send(24'sd100);
    send(24'sd100);
    enable = 1'b0;
    model_clear();
    idle(1);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b expected 0", busy); end
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL disable_hold_valid: got %b expected 1", bus.out_valid); end
    if (bus.out_data !== 24'd9) begin errors++; $display("FAIL disable_hold_data: got %0d expected 9", bus.out_data); end
    enable = 1'b1;
    idle(1);
    bus.out_ready = 1'b1;
    repeat (4) send(24'sd1);
    wait_drain("enable_drop");
  endtask

  task automatic test_latch();
    log2_n = 4'd2;
    send(24'sd10);
    log2_n = 4'd0;
    send(24'sd20); send(24'sd30); send(24'sd40);
    wait_drain("latch");
    idle(4);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latch_no_extra: out_valid got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    log2_n = 4'd0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) send(DW'($urandom_range(0, (1 << DW) - 1)));
    wait_drain("back_to_back");
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL back_to_back_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_random();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      log2_n = 4'($urandom_range(0, 3));
      send(DW'($urandom()));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    while (m_cnt != 0) send(DW'($urandom()));
    wait_drain("random");
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL random_overrun: got %b expected 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_block();
    test_basic();
    test_floor();
    test_wide();
    test_overrun();
    test_enable_drop();
    test_latch();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ads_sample_decimator.md
ADS_SAMPLE_DECIMATOR -- requirements
Module: ads_sample_decimator

Interface
REQ-001 Parameter DATA_WIDTH, default 24, sets the sample width; samples are two's complement.
REQ-002 Parameter MAX_LOG2_N, default 8, sets the largest supported block size as a log2 value.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 enable  input  1  1 = decimation runs; 0 = discard partial block and idle.
REQ-006 log2_n  input  4  block size N = 2^log2_n; values above MAX_LOG2_N are clamped to MAX_LOG2_N.
REQ-007 in_valid  input  1  one-cycle strobe; the sample on in_data is valid (ADC controller DONE output).
REQ-008 in_data  input  DATA_WIDTH  ADC sample.
REQ-009 out_ready  input  1  the consumer accepts out_data.
REQ-010 clear_overrun  input  1  clears the sticky overrun flag.
REQ-011 out_valid  output  1  the averaged result is held.
REQ-012 out_data  output  DATA_WIDTH  block mean, arithmetic shift of the sum, rounded toward minus infinity.
REQ-013 out_min / out_max  output  DATA_WIDTH each  signed minimum and maximum sample of the block.
REQ-014 overrun  output  1  sticky flag; a completed result was dropped.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 The FSM states SHALL be IDLE, ACCUM and EMIT.
REQ-017 IDLE->ACCUM when enable=1; any state->IDLE when enable=0, discarding the partial sum, count and min/max.
REQ-018 The first sample of a block SHALL load the accumulator and min/max and latch the clamped log2_n for the whole block; later log2_n changes apply only to the next block.
REQ-019 The accumulator width SHALL be DATA_WIDTH+MAX_LOG2_N; sign-extension is mandatory, so overflow cannot occur.
REQ-020 ACCUM->EMIT on the accepted sample that makes count == N; N=1 (log2_n=0) goes to EMIT after every sample.
REQ-021 EMIT SHALL last exactly 1 cycle; it computes sum>>>log2_n (arithmetic) and returns to ACCUM.
REQ-022 An in_valid sample during EMIT SHALL be accepted as the first sample of the next block; no sample is lost.
REQ-023 Latency: out_valid SHALL rise 2 cycles after the final sample's in_valid cycle.
REQ-024 out_valid, out_data, out_min and out_max SHALL hold stable until a cycle with out_valid && out_ready.
REQ-025 If a result completes while out_valid=1 and out_ready=0, the new result SHALL be dropped, the old one kept, and overrun set.
REQ-026 If a result completes in the same cycle as out_valid && out_ready, the new result SHALL load, out_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-027 overrun SHALL clear on clear_overrun; if a set event and clear_overrun occur in the same cycle, set wins.
REQ-028 Deasserting enable SHALL NOT clear a pending out_valid result.

Reset
REQ-029 rst SHALL force state=IDLE, count=0, accumulator=0, out_valid=0, out_data=out_min=out_max=0, overrun=0 and busy=0.
REQ-030 rst mid-block SHALL discard the partial block; the first post-reset block starts with the first sample after enable while rst=0.

Structure
REQ-031 Package ads_pkg SHALL hold the FSM state enum, ADS_DATA_WIDTH=24 and ADS_MAX_LOG2_N=8, shared with the ADC controller.
REQ-032 Sub-module ads_minmax_track SHALL implement the signed min/max registers with load and update inputs; all other logic stays flat.

Verification
REQ-033 log2_n=2, samples 4,8,12,16 -> out_data=10, out_min=4, out_max=16, out_valid rises 2 cycles after the 4th strobe.
REQ-034 log2_n=1, samples -3,-4 -> sum=-7, out_data=-4 (floor), out_min=-4, out_max=-3.
REQ-035 log2_n=8, 256 samples of 0x7FFFFF -> out_data=0x7FFFFF, no wrap; then 256 samples of 0x800000 -> out_data=0x800000.
REQ-036 log2_n=0, out_ready=0, samples 5 then 6 -> out_data stays 5, overrun=1; then clear_overrun pulse -> overrun=0.
REQ-037 log2_n=2, enable dropped after 2 samples, re-enabled, then 4 samples of 1 -> out_data=1, the earlier partial block is ignored.
REQ-038 log2_n=0, out_ready=1 constantly, an in_valid strobe every cycle -> one result per cycle after 2-cycle latency, overrun stays 0.
